// File: rtl/riscv_core_irq_pkg.sv
// Shared types and mcause codes for the machine-mode interrupt controller.
package riscv_core_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } irq_state_e;

  localparam int CAUSE_MTI        = 7;
  localparam int CAUSE_LOCAL_BASE = 16;

endpackage

// File: rtl/riscv_core_irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins, with a valid flag.
module riscv_core_irq_prio_enc #(
  parameter int WIDTH = 8,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_req,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  assign o_valid = |i_req;

  // Scan downward so the lowest requesting index is the last one written.
  always_comb begin
    o_idx = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      o_idx = i_req[k] ? IDX_W'(k) : o_idx;
    end
  end

endmodule

// File: rtl/riscv_core_irq_ctrl.sv
// Machine-mode interrupt controller: external lines plus mtime/mtimecmp timer.
// Build option RISCV_CORE_IRQ_EDGE_EN: edge-triggered pending held until acknowledged.
module riscv_core_irq_ctrl
  import riscv_core_irq_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NUM_IRQ = 8
) (
  input  logic               i_riscv_core_clk,
  input  logic               i_riscv_core_rst_n,
  input  logic [NUM_IRQ-1:0] i_riscv_core_irq,
  input  logic               i_riscv_core_mstatus_mie,
  input  logic               i_riscv_core_en_wen,
  input  logic [NUM_IRQ:0]   i_riscv_core_en_wdata,
  input  logic               i_riscv_core_mtimecmp_wen,
  input  logic [XLEN-1:0]    i_riscv_core_mtimecmp_wdata,
  input  logic               i_riscv_core_trap_ready,
  input  logic               i_riscv_core_mret,
  output logic               o_riscv_core_trap_req,
  output logic [XLEN-1:0]    o_riscv_core_trap_cause,
  output logic [NUM_IRQ-1:0] o_riscv_core_irq_ack,
  output logic [XLEN-1:0]    o_riscv_core_mtime,
  output logic               o_riscv_core_mtip
);

  localparam int CAND_W = NUM_IRQ + 1;
  localparam int IDX_W  = $clog2(CAND_W);

  irq_state_e         r_state;
  irq_state_e         w_state_nxt;
  logic [XLEN-1:0]    r_mtime;
  logic [XLEN-1:0]    r_mtimecmp;
  logic               r_mtip;
  logic [NUM_IRQ:0]   r_en;
  logic [NUM_IRQ-1:0] r_pending;
  logic [IDX_W-1:0]   r_winner;
  logic [XLEN-1:0]    r_cause;
  logic               r_trap_req;
  logic [NUM_IRQ-1:0] r_ack;

  logic [CAND_W-1:0]  w_cand;
  logic               w_win_valid;
  logic [IDX_W-1:0]   w_win_idx;
  logic [7:0]         w_code;
  logic [XLEN-1:0]    w_new_cause;
  logic               w_take;
  logic               w_accept;
  logic [NUM_IRQ-1:0] w_ack_onehot;

  // Timer sits above the external lines so the encoder ranks it last.
  assign w_cand = {r_mtip & r_en[NUM_IRQ], r_pending & r_en[NUM_IRQ-1:0]};

  riscv_core_irq_prio_enc #(
    .WIDTH (CAND_W),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .i_req   (w_cand),
    .o_valid (w_win_valid),
    .o_idx   (w_win_idx)
  );

  // Cause code for the current encoder winner.
  always_comb begin
    if (w_win_idx == IDX_W'(NUM_IRQ)) begin
      w_code = 8'(CAUSE_MTI);
    end else begin
      w_code = 8'(CAUSE_LOCAL_BASE) + 8'(w_win_idx);
    end
    w_new_cause = {1'b1, {(XLEN-9){1'b0}}, w_code};
  end

  // One-hot decode of the latched winner for the acknowledge pulse.
  always_comb begin
    w_ack_onehot = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      w_ack_onehot[k] = (r_winner == IDX_W'(k));
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_riscv_core_mstatus_mie && w_win_valid) begin
          w_state_nxt = ST_REQ;
          w_take      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (i_riscv_core_trap_ready) begin
          w_state_nxt = ST_ACTIVE;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_ACTIVE: begin
        if (i_riscv_core_mret) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACTIVE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, latched winner/cause and registered request/ack outputs.
  always_ff @(posedge i_riscv_core_clk or negedge i_riscv_core_rst_n) begin
    if (!i_riscv_core_rst_n) begin
      r_state    <= ST_IDLE;
      r_winner   <= '0;
      r_cause    <= '0;
      r_trap_req <= 1'b0;
      r_ack      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_trap_req <= (w_state_nxt == ST_REQ);
      if (w_take) begin
        r_winner <= w_win_idx;
        r_cause  <= w_new_cause;
      end else if (w_state_nxt == ST_IDLE) begin
        r_cause  <= '0;
      end
      if (w_accept && (r_winner != IDX_W'(NUM_IRQ))) begin
        r_ack <= w_ack_onehot;
      end else begin
        r_ack <= '0;
      end
    end
  end

  // Timer, compare register, enables.
  always_ff @(posedge i_riscv_core_clk or negedge i_riscv_core_rst_n) begin
    if (!i_riscv_core_rst_n) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_mtip     <= 1'b0;
      r_en       <= '0;
    end else begin
      r_mtime <= r_mtime + XLEN'(1);
      r_mtip  <= (r_mtime >= r_mtimecmp);
      if (i_riscv_core_mtimecmp_wen) begin
        r_mtimecmp <= i_riscv_core_mtimecmp_wdata;
      end
      if (i_riscv_core_en_wen) begin
        r_en <= i_riscv_core_en_wdata;
      end
    end
  end

`ifdef RISCV_CORE_IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] r_irq_d;

  // A fresh rising edge wins over a coincident acknowledge.
  always_ff @(posedge i_riscv_core_clk or negedge i_riscv_core_rst_n) begin
    if (!i_riscv_core_rst_n) begin
      r_irq_d   <= '0;
      r_pending <= '0;
    end else begin
      r_irq_d   <= i_riscv_core_irq;
      r_pending <= (r_pending & ~r_ack) | (i_riscv_core_irq & ~r_irq_d);
    end
  end
`else
  // Level-sensitive pending: registered copy of the lines.
  always_ff @(posedge i_riscv_core_clk or negedge i_riscv_core_rst_n) begin
    if (!i_riscv_core_rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= i_riscv_core_irq;
    end
  end
`endif

  assign o_riscv_core_trap_req   = r_trap_req;
  assign o_riscv_core_trap_cause = r_cause;
  assign o_riscv_core_irq_ack    = r_ack;
  assign o_riscv_core_mtime      = r_mtime;
  assign o_riscv_core_mtip       = r_mtip;

endmodule

// File: tb/tb_riscv_core_irq_ctrl.sv
// Directed self-checking bench for riscv_core_irq_ctrl (default parameters).
module tb_riscv_core_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq;
  logic        mie;
  logic        en_wen;
  logic [8:0]  en_wdata;
  logic        cmp_wen;
  logic [63:0] cmp_wdata;
  logic        trap_ready;
  logic        mret;
  logic        trap_req;
  logic [63:0] cause;
  logic [7:0]  ack;
  logic [63:0] mtime;
  logic        mtip;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_core_irq_ctrl dut (
    .i_riscv_core_clk            (clk),
    .i_riscv_core_rst_n          (rst_n),
    .i_riscv_core_irq            (irq),
    .i_riscv_core_mstatus_mie    (mie),
    .i_riscv_core_en_wen         (en_wen),
    .i_riscv_core_en_wdata       (en_wdata),
    .i_riscv_core_mtimecmp_wen   (cmp_wen),
    .i_riscv_core_mtimecmp_wdata (cmp_wdata),
    .i_riscv_core_trap_ready     (trap_ready),
    .i_riscv_core_mret           (mret),
    .o_riscv_core_trap_req       (trap_req),
    .o_riscv_core_trap_cause     (cause),
    .o_riscv_core_irq_ack        (ack),
    .o_riscv_core_mtime          (mtime),
    .o_riscv_core_mtip           (mtip)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; irq = 8'h00; mie = 1'b0; en_wen = 1'b0; en_wdata = 9'h000;
    cmp_wen = 1'b0; cmp_wdata = 64'h0; trap_ready = 1'b0; mret = 1'b0;
    step(); step();
    chk("rst_trap_req", {63'd0, trap_req}, 64'd0);
    chk("rst_cause", cause, 64'd0);
    chk("rst_ack", {56'd0, ack}, 64'd0);
    chk("rst_mtime", mtime, 64'd0);
    chk("rst_mtip", {63'd0, mtip}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("mtime_inc", mtime, 64'd1);
    chk("mtip_cmp_ones", {63'd0, mtip}, 64'd0);

    // Single line 3, trap_ready tied high.
    irq = 8'h08; en_wen = 1'b1; en_wdata = 9'h008; mie = 1'b1; trap_ready = 1'b1;
    step();
    en_wen = 1'b0;
    chk("l3_no_req_yet", {63'd0, trap_req}, 64'd0);
    step();
    chk("l3_req", {63'd0, trap_req}, 64'd1);
    chk("l3_cause", cause, 64'h8000_0000_0000_0013);
    chk("l3_no_ack_in_req", {56'd0, ack}, 64'd0);
    step();
    chk("l3_req_dropped", {63'd0, trap_req}, 64'd0);
    chk("l3_ack", {56'd0, ack}, 64'h08);
    irq = 8'h00; mret = 1'b1;
    step();
    mret = 1'b0;
    chk("l3_ack_one_cycle", {56'd0, ack}, 64'd0);
    chk("l3_idle_cause", cause, 64'd0);
    step();
    chk("l3_no_reentry", {63'd0, trap_req}, 64'd0);

    // Lines 1 and 5 together: 1 wins, then 5 after mret.
    irq = 8'h22; en_wen = 1'b1; en_wdata = 9'h0FF;
    step();
    en_wen = 1'b0;
    step();
    chk("p15_req", {63'd0, trap_req}, 64'd1);
    chk("p15_cause_17", cause, 64'h8000_0000_0000_0011);
    step();
    chk("p15_ack1", {56'd0, ack}, 64'h02);
    irq = 8'h20; mret = 1'b1;
    step();
    mret = 1'b0;
    chk("p15_idle_after_mret", {63'd0, trap_req}, 64'd0);
    step();
    chk("p15_req2", {63'd0, trap_req}, 64'd1);
    chk("p15_cause_21", cause, 64'h8000_0000_0000_0015);
    step();
    chk("p15_ack5", {56'd0, ack}, 64'h20);
    irq = 8'h00; mret = 1'b1;
    step();
    mret = 1'b0;

    // Global enable gating.
    mie = 1'b0; irq = 8'h04;
    step(); step();
    chk("mie0_no_req_a", {63'd0, trap_req}, 64'd0);
    step();
    chk("mie0_no_req_b", {63'd0, trap_req}, 64'd0);
    mie = 1'b1;
    step();
    chk("mie1_req", {63'd0, trap_req}, 64'd1);
    chk("mie1_cause", cause, 64'h8000_0000_0000_0012);
    step();
    chk("mie1_ack", {56'd0, ack}, 64'h04);
    irq = 8'h00; mret = 1'b1;
    step();
    mret = 1'b0;

    // Stall in REQ while the line, mie and enables change and mret is ignored.
    trap_ready = 1'b0; irq = 8'h40;
    step(); step();
    chk("hold_req", {63'd0, trap_req}, 64'd1);
    chk("hold_cause", cause, 64'h8000_0000_0000_0016);
    irq = 8'h00; mie = 1'b0; en_wen = 1'b1; en_wdata = 9'h000; mret = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_req_cyc", {63'd0, trap_req}, 64'd1);
      chk("hold_cause_cyc", cause, 64'h8000_0000_0000_0016);
    end
    en_wen = 1'b0; mret = 1'b0; trap_ready = 1'b1;
    step();
    chk("hold_ack", {56'd0, ack}, 64'h40);
    chk("hold_req_cleared", {63'd0, trap_req}, 64'd0);
    mret = 1'b1;
    step();
    mret = 1'b0; mie = 1'b1;

    // Enable write coinciding with IDLE selection uses the old enables.
    irq = 8'h01;
    step();
    chk("enw_pending_disabled", {63'd0, trap_req}, 64'd0);
    en_wen = 1'b1; en_wdata = 9'h001;
    step();
    en_wen = 1'b0;
    chk("enw_old_enable_used", {63'd0, trap_req}, 64'd0);
    step();
    chk("enw_req_new_enable", {63'd0, trap_req}, 64'd1);
    chk("enw_cause_16", cause, 64'h8000_0000_0000_0010);
    step();
    chk("enw_ack0", {56'd0, ack}, 64'h01);
    irq = 8'h00; mret = 1'b1;
    step();
    mret = 1'b0;

    // Reset asserted mid-REQ.
    trap_ready = 1'b0; irq = 8'h80; en_wen = 1'b1; en_wdata = 9'h080;
    step();
    en_wen = 1'b0;
    step();
    chk("rstreq_in_req", {63'd0, trap_req}, 64'd1);
    chk("rstreq_cause", cause, 64'h8000_0000_0000_0017);
    rst_n = 1'b0;
    #1;
    chk("rstreq_req_cleared", {63'd0, trap_req}, 64'd0);
    chk("rstreq_cause_cleared", cause, 64'd0);
    chk("rstreq_mtime_cleared", mtime, 64'd0);
    trap_ready = 1'b1;
    step();
    chk("rstreq_no_ack", {56'd0, ack}, 64'd0);

    // Timer: mtimecmp=20 from a fresh reset.
    irq = 8'h00; cmp_wen = 1'b1; cmp_wdata = 64'd20; en_wen = 1'b1; en_wdata = 9'h100;
    rst_n = 1'b1;
    step();
    cmp_wen = 1'b0; en_wen = 1'b0;
    chk("tmr_ack_after_rst", {56'd0, ack}, 64'd0);
    repeat (19) step();
    chk("tmr_mtime20", mtime, 64'd20);
    chk("tmr_mtip_low", {63'd0, mtip}, 64'd0);
    step();
    chk("tmr_mtime21", mtime, 64'd21);
    chk("tmr_mtip_high", {63'd0, mtip}, 64'd1);
    chk("tmr_no_req_yet", {63'd0, trap_req}, 64'd0);
    step();
    chk("tmr_req", {63'd0, trap_req}, 64'd1);
    chk("tmr_cause", cause, 64'h8000_0000_0000_0007);
    step();
    chk("tmr_no_ack", {56'd0, ack}, 64'd0);
    chk("tmr_req_cleared", {63'd0, trap_req}, 64'd0);
    mret = 1'b1; en_wen = 1'b1; en_wdata = 9'h000;
    step();
    chk("tmr_no_ack_b", {56'd0, ack}, 64'd0);
    mret = 1'b0; en_wen = 1'b0;
    step();
    chk("tmr_disabled", {63'd0, trap_req}, 64'd0);

`ifdef RISCV_CORE_IRQ_EDGE_EN
    // One-cycle pulse on line 0 while ACTIVE is remembered until after mret.
    irq = 8'h04; en_wen = 1'b1; en_wdata = 9'h005;
    step();
    en_wen = 1'b0;
    step();
    chk("edge_req2", cause, 64'h8000_0000_0000_0012);
    step();
    chk("edge_ack2", {56'd0, ack}, 64'h04);
    irq = 8'h01;
    step();
    irq = 8'h00;
    chk("edge_active_no_req", {63'd0, trap_req}, 64'd0);
    step();
    mret = 1'b1;
    step();
    mret = 1'b0;
    chk("edge_idle", {63'd0, trap_req}, 64'd0);
    step();
    chk("edge_req0", {63'd0, trap_req}, 64'd1);
    chk("edge_cause0", cause, 64'h8000_0000_0000_0010);
    step();
    chk("edge_ack0", {56'd0, ack}, 64'h01);
    mret = 1'b1;
    step();
    mret = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_core_irq_ctrl.md
RISCV_CORE_IRQ_CTRL -- requirements
Module: riscv_core_irq_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, data/cause/timer width.
REQ-002 SHALL have parameter NUM_IRQ, default 8, range 1..32, number of external interrupt lines.
REQ-003 SHALL have port i_riscv_core_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_riscv_core_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_riscv_core_irq  input  NUM_IRQ  external interrupt lines, synchronous to clock.
REQ-006 SHALL have port i_riscv_core_mstatus_mie  input  1  global machine interrupt enable.
REQ-007 SHALL have ports i_riscv_core_en_wen (input, 1) and i_riscv_core_en_wdata (input, NUM_IRQ+1), the enable-register write; bit NUM_IRQ is the timer enable.
REQ-008 SHALL have ports i_riscv_core_mtimecmp_wen (input, 1) and i_riscv_core_mtimecmp_wdata (input, XLEN), the compare-register write.
REQ-009 SHALL have port i_riscv_core_trap_ready  input  1  pipeline accepts the trap this cycle.
REQ-010 SHALL have port i_riscv_core_mret  input  1  handler return, single-cycle pulse.
REQ-011 SHALL have port o_riscv_core_trap_req  output  1  interrupt trap request.
REQ-012 SHALL have port o_riscv_core_trap_cause  output  XLEN  mcause value for the request.
REQ-013 SHALL have port o_riscv_core_irq_ack  output  NUM_IRQ  one-hot acknowledge pulse.
REQ-014 SHALL have ports o_riscv_core_mtime (output, XLEN, free-running counter) and o_riscv_core_mtip (output, 1, timer pending).

Function
REQ-015 mtime SHALL increment by 1 every cycle and wrap from all-ones to 0.
REQ-016 mtip SHALL be registered: mtime >= mtimecmp (unsigned), one cycle latency.
REQ-017 pending[k] SHALL be level-sensitive: the registered value of irq[k].
REQ-018 The candidate set SHALL be pending & en; the timer is a candidate when mtip & en[NUM_IRQ].
REQ-019 Priority SHALL be: lowest-index external line highest, all external lines above timer.
REQ-020 Cause SHALL be {1'b1, code}; line k gives code 16+k and the timer gives code 7.
REQ-021 The FSM SHALL have states IDLE, REQ and ACTIVE.
REQ-022 IDLE->REQ SHALL occur when mstatus_mie=1 and any candidate exists; the winner and cause latch on this edge.
REQ-023 In REQ, trap_req SHALL be 1 and cause SHALL stay stable, even if the line deasserts or en/mie changes, until trap_ready=1.
REQ-024 REQ->ACTIVE SHALL occur on trap_ready=1; irq_ack[winner] SHALL pulse one cycle in the following cycle; the timer winner pulses no ack.
REQ-025 ACTIVE->IDLE SHALL occur on mret=1.
REQ-026 mret SHALL be ignored in IDLE and REQ; trap_ready SHALL be ignored in IDLE and ACTIVE.
REQ-027 An enable write in the same cycle as IDLE selection SHALL NOT affect that selection; the old enables are used.
REQ-028 In IDLE, cause SHALL read 0.
REQ-029 After mret, re-entry to REQ SHALL be no earlier than the next cycle.

Reset
REQ-030 On reset: state=IDLE, trap_req=0, trap_cause=0, irq_ack=0, en=0, pending=0, mtime=0, mtip=0, mtimecmp=all-ones.
REQ-031 Reset asserted mid-REQ or mid-ACTIVE SHALL return to IDLE immediately with no ack pulse.

Configuration
REQ-032 Macro RISCV_CORE_IRQ_EDGE_EN SHALL be the only configuration macro.
REQ-033 When RISCV_CORE_IRQ_EDGE_EN is defined, pending[k] SHALL set on a 0->1 edge of irq[k] and clear only on irq_ack[k].
REQ-034 When RISCV_CORE_IRQ_EDGE_EN is defined and a new edge coincides with its ack, pending[k] SHALL remain set.
REQ-035 When RISCV_CORE_IRQ_EDGE_EN is undefined, pending SHALL be level-sensitive per REQ-017.

Structure
REQ-036 Package riscv_core_irq_pkg SHALL hold the state enum, CAUSE_MTI=7 and CAUSE_LOCAL_BASE=16.
REQ-037 Sub-module riscv_core_irq_prio_enc SHALL be parametrised by width and output a valid flag and a binary index.

Verification
REQ-038 Directed: irq[3]=1, en=0x008, mie=1, trap_ready tied 1 -> trap_req for 1 cycle, cause=0x8000_0000_0000_0013, ack=0x08 on the next cycle.
REQ-039 Directed: irq[1] and irq[5] both asserted with en=0x0FF -> cause code 17 wins; after mret, code 21 is taken.
REQ-040 Directed: mtimecmp=20, en=0x100 -> mtip high at mtime 21; cause=0x8000_0000_0000_0007; no ack pulse.
REQ-041 Directed: trap_ready held 0 for 5 cycles while irq drops -> trap_req and cause held steady for all 5 cycles.
REQ-042 Directed: mie=0 with a pending irq -> no request; raising mie -> trap_req on the next edge.
REQ-043 Directed with RISCV_CORE_IRQ_EDGE_EN: 1-cycle pulse on irq[0] while ACTIVE -> request taken after mret.
